// File: rtl/rcb_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rcb_ram_ctrl
// Purpose : Single-port RAM controller arbitrating lookup reads against
//           byte-masked host writes (read-modify-write).
// Revision: 1.0
// ============================================================================
module rcb_ram_ctrl #(
    parameter int RCB_ADDR_WIDTH  = 10,
    parameter int RCB_DATA_WIDTH  = 64,
    parameter int RCB_BE_WIDTH    = RCB_DATA_WIDTH / 8,
    parameter int RD_LATENCY      = 2,
    parameter int WR_STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      hpb_wr_req,
    input  logic [RCB_ADDR_WIDTH-1:0] hpb_wr_addr,
    input  logic [RCB_DATA_WIDTH-1:0] hpb_wr_data,
    input  logic [RCB_BE_WIDTH-1:0]   hpb_wr_byte_en,
    output logic                      rcb_wr_done,
    input  logic                      lkp_valid,
    input  logic [RCB_ADDR_WIDTH-1:0] lkp_addr,
    output logic                      lkp_ready,
    output logic                      rsp_valid,
    output logic [RCB_DATA_WIDTH-1:0] rsp_data,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [RCB_ADDR_WIDTH-1:0] ram_addr,
    output logic [RCB_DATA_WIDTH-1:0] ram_wdata,
    input  logic [RCB_DATA_WIDTH-1:0] ram_rdata
);

    localparam int              STARVE_W   = $clog2(WR_STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(WR_STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ISSUE  = 3'd1,
        RD_WAIT   = 3'd2,
        WR_ISSUE  = 3'd3,
        DONE      = 3'd4,
        DROP_WAIT = 3'd5
    } state_t;

    state_t                    state;
    logic [RCB_ADDR_WIDTH-1:0] wr_addr;
    logic [RCB_DATA_WIDTH-1:0] wr_data;
    logic [RCB_BE_WIDTH-1:0]   wr_be;
    logic [RCB_DATA_WIDTH-1:0] rd_capt;
    logic [STARVE_W-1:0]       starve_cnt;
    logic [RD_LATENCY-1:0]     tag_vld;
    logic [RD_LATENCY-1:0]     tag_lkp;
    logic [RCB_DATA_WIDTH-1:0] merged;

    logic wr_pend;
    logic lkp_grant;
    logic wr_grant;
    logic rmw_ret;

    // Reset gates every strobe so an abandoned access never reaches the RAM or the response port.
    assign wr_pend   = reset_n && ((state == RD_ISSUE) || (state == WR_ISSUE));
    assign lkp_ready = !(wr_pend && (starve_cnt == STARVE_MAX));
    assign lkp_grant = reset_n && lkp_valid && lkp_ready;
    assign wr_grant  = wr_pend && !lkp_grant;

    assign ram_en    = lkp_grant || wr_grant;
    assign ram_we    = wr_grant && (state == WR_ISSUE);
    assign ram_addr  = lkp_grant ? lkp_addr : wr_addr;
    assign ram_wdata = merged;

    assign rsp_valid = reset_n && tag_vld[RD_LATENCY-1] && tag_lkp[RD_LATENCY-1];
    assign rsp_data  = ram_rdata;
    assign rmw_ret   = tag_vld[RD_LATENCY-1] && !tag_lkp[RD_LATENCY-1];

    generate
        for (genvar i = 0; i < RCB_BE_WIDTH; i++) begin : g_merge
            assign merged[8*i +: 8] = wr_be[i] ? wr_data[8*i +: 8] : rd_capt[8*i +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_vld <= '0;
            tag_lkp <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_lkp[i] <= tag_lkp[i-1];
            end
            tag_vld[0] <= ram_en && !ram_we;
            tag_lkp[0] <= lkp_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (wr_grant) begin
            starve_cnt <= '0;
        end else if (wr_pend && lkp_grant && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_be       <= '0;
            rd_capt     <= '0;
            rcb_wr_done <= 1'b0;
        end else begin
            rcb_wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hpb_wr_req) begin
                        wr_addr <= hpb_wr_addr;
                        wr_data <= hpb_wr_data;
                        wr_be   <= hpb_wr_byte_en;
                        if (~|hpb_wr_byte_en) begin
                            state       <= DONE;
                            rcb_wr_done <= 1'b1;
                        end else if (&hpb_wr_byte_en) begin
                            state <= WR_ISSUE;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (wr_grant) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rmw_ret) begin
                        rd_capt <= ram_rdata;
                        state   <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (wr_grant) begin
                        state       <= DONE;
                        rcb_wr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DROP_WAIT;
                end
                DROP_WAIT: begin
                    if (!hpb_wr_req) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rcb_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rcb_ram_ctrl
// Purpose : Directed self-checking bench for rcb_ram_ctrl with a RAM model.
// Revision: 1.0
// ============================================================================
module tb_rcb_ram_ctrl;

    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int BW  = 8;
    localparam int LAT = 2;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          hpb_wr_req = 1'b0;
    logic [AW-1:0] hpb_wr_addr = '0;
    logic [DW-1:0] hpb_wr_data = '0;
    logic [BW-1:0] hpb_wr_byte_en = '0;
    logic          rcb_wr_done;
    logic          lkp_valid = 1'b0;
    logic [AW-1:0] lkp_addr = '0;
    logic          lkp_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rcb_ram_ctrl #(
        .RCB_ADDR_WIDTH (AW),
        .RCB_DATA_WIDTH (DW),
        .RCB_BE_WIDTH   (BW),
        .RD_LATENCY     (LAT),
        .WR_STARVE_LIMIT(LIM)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hpb_wr_req    (hpb_wr_req),
        .hpb_wr_addr   (hpb_wr_addr),
        .hpb_wr_data   (hpb_wr_data),
        .hpb_wr_byte_en(hpb_wr_byte_en),
        .rcb_wr_done   (rcb_wr_done),
        .lkp_valid     (lkp_valid),
        .lkp_addr      (lkp_addr),
        .lkp_ready     (lkp_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    function automatic logic [63:0] pat(input int i);
        return {32'hC0DE0000 + 32'(i), 32'h0BADF00D ^ 32'(i)};
    endfunction

    // Two-stage read pipeline matches the controller's RD_LATENCY of 2.
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] rp0 = '0;
    logic [DW-1:0] rp1 = '0;
    assign ram_rdata = rp1;
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        mem[18] = 64'h1122334455667788;
        forever begin
            @(posedge clk);
            if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
            rp1 <= rp0;
            rp0 <= (ram_en && !ram_we) ? mem[ram_addr] : 64'hDEADBEEFDEADBEEF;
        end
    end

    int            wr_cnt = 0, rd_cnt = 0, done_cnt = 0, rsp_cnt = 0, en_cnt = 0;
    int            last_wr_cyc = 0, last_done_cyc = 0;
    logic [DW-1:0] last_wr_data = '0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] rsp_log [0:255];
    int            rsp_cyc_log [0:255];
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (ram_en) begin
                en_cnt++;
                if (ram_we) begin
                    wr_cnt++;
                    last_wr_cyc  = cyc;
                    last_wr_data = ram_wdata;
                    last_wr_addr = ram_addr;
                end else begin
                    rd_cnt++;
                end
            end
            if (rcb_wr_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (rsp_valid) begin
                rsp_log[rsp_cnt % 256]     = rsp_data;
                rsp_cyc_log[rsp_cnt % 256] = cyc;
                rsp_cnt++;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raises a write request and returns once done has been seen plus 'hold' cycles.
    task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be, input int hold, output int t0);
        int d0;
        int n;
        @(negedge clk);
        t0 = cyc;
        d0 = done_cnt;
        hpb_wr_req = 1'b1;
        hpb_wr_addr = a;
        hpb_wr_data = d;
        hpb_wr_byte_en = be;
        n = 0;
        while ((done_cnt == d0) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
        repeat (hold) @(negedge clk);
    endtask

    task automatic drop_req();
        @(negedge clk);
        hpb_wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic lookup_one(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
        int r0;
        @(negedge clk);
        r0 = rsp_cnt;
        lkp_valid = 1'b1;
        lkp_addr = a;
        @(negedge clk);
        lkp_valid = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_cnt"}, 64'(rsp_cnt - r0), 64'd1);
        check(tag, rsp_log[r0 % 256], e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"},  64'(rcb_wr_done), 64'd0);
        check({tag, "_rsp"},   64'(rsp_valid),   64'd0);
        check({tag, "_en"},    64'(ram_en),      64'd0);
        check({tag, "_we"},    64'(ram_we),      64'd0);
        check({tag, "_ready"}, 64'(lkp_ready),   64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] exp_mem [0:31];
    int t0, w0, d0, r0, rd0, e0, idx, nst, stall1, stall2, nr;

    initial begin
        for (int i = 0; i < 32; i++) exp_mem[i] = pat(i);
        exp_mem[18] = 64'h1122334455667788;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Partial mask: read at 1, write at 4, done at 5.
        w0 = wr_cnt; rd0 = rd_cnt; d0 = done_cnt;
        do_write("partial", 10'h012, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 2, t0);
        check("partial_wr_cnt",  64'(wr_cnt - w0),      64'd1);
        check("partial_rd_cnt",  64'(rd_cnt - rd0),     64'd1);
        check("partial_wr_cyc",  64'(last_wr_cyc - t0), 64'd4);
        check("partial_wr_addr", 64'(last_wr_addr),     64'h012);
        check("partial_wr_data", last_wr_data,          64'h11223344AAAAAAAA);
        check("partial_done_n",  64'(done_cnt - d0),    64'd1);
        check("partial_done_cyc", 64'(last_done_cyc - t0), 64'd5);
        drop_req();
        exp_mem[18] = 64'h11223344AAAAAAAA;

        // Full mask: no read, write at 1, done at 2.
        w0 = wr_cnt; rd0 = rd_cnt;
        do_write("full", 10'h020, 64'h0123456789ABCDEF, 8'hFF, 1, t0);
        check("full_rd_cnt",   64'(rd_cnt - rd0),        64'd0);
        check("full_wr_cnt",   64'(wr_cnt - w0),         64'd1);
        check("full_wr_cyc",   64'(last_wr_cyc - t0),    64'd1);
        check("full_wr_data",  last_wr_data,             64'h0123456789ABCDEF);
        check("full_done_cyc", 64'(last_done_cyc - t0),  64'd2);
        drop_req();
        lookup_one("full_readback", 10'h020, 64'h0123456789ABCDEF);

        // Zero mask: no RAM traffic, done at 1.
        e0 = en_cnt;
        do_write("zero", 10'h021, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1, t0);
        check("zero_en_cnt",   64'(en_cnt - e0),        64'd0);
        check("zero_done_cyc", 64'(last_done_cyc - t0), 64'd1);
        drop_req();
        lookup_one("zero_readback", 10'h021, pat(33));

        // Back-to-back lookups 0..15.
        @(negedge clk);
        t0 = cyc; r0 = rsp_cnt; nr = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            lkp_valid = 1'b1;
            lkp_addr = AW'(i);
            #1;
            if (!lkp_ready) nr++;
        end
        @(negedge clk);
        lkp_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_ready_drops", 64'(nr), 64'd0);
        check("b2b_rsp_cnt",     64'(rsp_cnt - r0), 64'd16);
        check("b2b_first_cyc",   64'(rsp_cyc_log[r0 % 256] - t0), 64'd2);
        check("b2b_last_cyc",    64'(rsp_cyc_log[(r0 + 15) % 256] - t0), 64'd17);
        for (int k = 0; k < 16; k++) check("b2b_data", rsp_log[(r0 + k) % 256], exp_mem[k]);

        // Continuous lookups against a partial write: forced grants at 9 and 20.
        @(negedge clk);
        t0 = cyc; r0 = rsp_cnt; w0 = wr_cnt; d0 = done_cnt; rd0 = rd_cnt;
        hpb_wr_req = 1'b1;
        hpb_wr_addr = 10'h012;
        hpb_wr_data = 64'h5555555555555555;
        hpb_wr_byte_en = 8'h0F;
        idx = 0; nst = 0; stall1 = -1; stall2 = -1;
        for (int n = 0; n < 30; n++) begin
            if (n > 0) @(negedge clk);
            lkp_valid = 1'b1;
            lkp_addr = AW'(idx);
            #1;
            if (lkp_ready) begin
                idx++;
            end else begin
                nst++;
                if (stall1 < 0) stall1 = cyc - t0;
                else stall2 = cyc - t0;
            end
        end
        @(negedge clk);
        lkp_valid = 1'b0;
        hpb_wr_req = 1'b0;
        repeat (4) @(negedge clk);
        check("starve_stalls",   64'(nst), 64'd2);
        check("starve_rd_stall", 64'(stall1), 64'd9);
        check("starve_wr_stall", 64'(stall2), 64'd20);
        check("starve_wr_cnt",   64'(wr_cnt - w0), 64'd1);
        check("starve_wr_cyc",   64'(last_wr_cyc - t0), 64'd20);
        check("starve_wr_data",  last_wr_data, 64'h1122334455555555);
        check("starve_done_n",   64'(done_cnt - d0), 64'd1);
        check("starve_done_cyc", 64'(last_done_cyc - t0), 64'd21);
        check("starve_accepted", 64'(idx), 64'd28);
        check("starve_rd_cnt",   64'(rd_cnt - rd0), 64'(idx + 1));
        check("starve_rsp_cnt",  64'(rsp_cnt - r0), 64'(idx));
        for (int k = 0; k < 28; k++) check("starve_rsp_data", rsp_log[(r0 + k) % 256], exp_mem[k]);
        exp_mem[18] = 64'h1122334455555555;
        lookup_one("hazard_new_data", 10'h012, exp_mem[18]);

        // Request held past done is not re-executed; the next one runs after the drop.
        w0 = wr_cnt; d0 = done_cnt;
        do_write("hold", 10'h030, 64'hA1A2A3A4A5A6A7A8, 8'hFF, 3, t0);
        check("hold_wr_cnt",   64'(wr_cnt - w0),   64'd1);
        check("hold_done_cnt", 64'(done_cnt - d0), 64'd1);
        drop_req();
        w0 = wr_cnt;
        do_write("second", 10'h030, 64'hB1B2B3B4B5B6B7B8, 8'hF0, 1, t0);
        check("second_wr_cnt",  64'(wr_cnt - w0),      64'd1);
        check("second_wr_cyc",  64'(last_wr_cyc - t0), 64'd4);
        check("second_wr_data", last_wr_data,          64'hB1B2B3B4A5A6A7A8);
        drop_req();

        // Reset while the RMW read is outstanding and a lookup is about to return.
        @(negedge clk);
        t0 = cyc; w0 = wr_cnt; d0 = done_cnt; r0 = rsp_cnt; rd0 = rd_cnt;
        hpb_wr_req = 1'b1;
        hpb_wr_addr = 10'h040;
        hpb_wr_data = 64'h7777777777777777;
        hpb_wr_byte_en = 8'h0F;
        @(negedge clk);
        lkp_valid = 1'b1;
        lkp_addr = 10'd5;
        @(negedge clk);
        lkp_addr = 10'd6;
        @(negedge clk);
        lkp_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_rsp_suppressed", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        hpb_wr_req = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midreset_wr_cnt",   64'(wr_cnt - w0),   64'd0);
        check("midreset_done_cnt", 64'(done_cnt - d0), 64'd0);
        check("midreset_rsp_cnt",  64'(rsp_cnt - r0),  64'd1);
        check("midreset_rd_cnt",   64'(rd_cnt - rd0),  64'd3);
        check("midreset_rsp_data", rsp_log[r0 % 256], pat(5));
        lookup_one("midreset_mem_intact", 10'h040, pat(64));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
